coproc_result_serializer: RTL and testbench

- Transmit-side counterpart of the UART coprocessor's wide input path.
- Takes the coprocessor's WIDTH_DOUT-bit result word, qualified by its slow-domain dout_valid level, and streams it byte-by-byte into the UART transmitter over a valid/ready byte interface.
- Sits between coprocessor dout/dout_valid and the UART TX core, in the fast clk domain.

---
 rtl/coproc_pkg.sv | 32 +++
 rtl/coproc_result_serializer_sync.sv | 43 ++++
 rtl/coproc_result_serializer.sv | 154 +++++++++++++++
 tb/tb_coproc_result_serializer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coproc_pkg.sv
// ---------------------------------------------------------------------------
// coproc_pkg
// Shared definitions for the coprocessor result serializer:
//   - default result width and bytes per word
//   - serializer state encoding
//   - ASCII anchors and a nibble-to-hex-character helper (used when the
//     COPROC_SER_HEX_ASCII_EN build option is defined)
// ---------------------------------------------------------------------------
package coproc_pkg;

  localparam int WIDTH_DOUT_DEFAULT = 128;
  localparam int BYTES_PER_WORD     = WIDTH_DOUT_DEFAULT / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_TERM = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;

  // 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return ASCII_ZERO + {4'd0, nib};
    end else begin
      return ASCII_UPPER_A + {4'd0, nib} - 8'd10;
    end
  endfunction

endpackage

// File: rtl/coproc_result_serializer_sync.sv
// ---------------------------------------------------------------------------
// sync_rise_detect
// Brings a slow-domain level into clk through two flops (s1, s2), keeps an
// edge register s3, and produces a one-cycle rise pulse.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous active-low reset
//   din  in  asynchronous level
//   rise out one-clk pulse per rising edge of din (registered)
// ---------------------------------------------------------------------------
module sync_rise_detect
  import coproc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic s1_reg;
  logic s2_reg;
  logic s3_reg;
  logic rise_reg;

  // The edge pulse s2 & ~s3 is itself registered so downstream capture
  // logic is driven straight from a flop rather than a gate after the sync.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_reg   <= 1'b0;
      s2_reg   <= 1'b0;
      s3_reg   <= 1'b0;
      rise_reg <= 1'b0;
    end else begin
      s1_reg   <= din;
      s2_reg   <= s1_reg;
      s3_reg   <= s2_reg;
      rise_reg <= s2_reg & ~s3_reg;
    end
  end

  assign rise = rise_reg;

endmodule

// File: rtl/coproc_result_serializer.sv
// ---------------------------------------------------------------------------
// coproc_result_serializer
// Captures a WIDTH_DOUT-bit coprocessor result on each rising edge of the
// slow-domain dout_valid level and streams it MSB byte first over a
// valid/ready byte interface to the UART transmitter, optionally followed
// by TERM_BYTE.
// Build option: COPROC_SER_HEX_ASCII_EN -- when defined, every byte is sent
// as two uppercase ASCII hex characters (high nibble first).
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-low reset
//   dout        in   result word, stable while dout_valid is high
//   dout_valid  in   slow-domain qualifier level
//   tx_data     out  byte to UART TX
//   tx_valid    out  tx_data valid
//   tx_ready    in   UART TX accepts (transfer = tx_valid && tx_ready)
//   busy        out  frame in progress
//   overrun     out  sticky: a word arrived while busy (cleared by reset)
// ---------------------------------------------------------------------------
module coproc_result_serializer
  import coproc_pkg::*;
#(
  parameter int         WIDTH_DOUT  = WIDTH_DOUT_DEFAULT,
  parameter int         APPEND_TERM = 1,
  parameter logic [7:0] TERM_BYTE   = 8'h0A
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH_DOUT-1:0] dout,
  input  logic                  dout_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  overrun
);

  localparam int NUM_BYTES = WIDTH_DOUT / 8;
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  state_t                state_reg, state_next;
  logic [WIDTH_DOUT-1:0] shreg_reg, shreg_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic                  overrun_reg, overrun_next;
  logic                  rise;
  logic                  xfer;
  logic                  byte_done;
`ifdef COPROC_SER_HEX_ASCII_EN
  logic                  nib_reg, nib_next;
`endif

  sync_rise_detect u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (dout_valid),
    .rise (rise)
  );

  assign tx_valid = (state_reg != ST_IDLE);
  assign busy     = tx_valid;
  assign overrun  = overrun_reg;
  assign xfer     = tx_valid && tx_ready;

`ifdef COPROC_SER_HEX_ASCII_EN
  // A byte is consumed only once its low-nibble character has gone out.
  assign byte_done = xfer && nib_reg;
`else
  assign byte_done = xfer;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      shreg_reg   <= '0;
      idx_reg     <= '0;
      overrun_reg <= 1'b0;
`ifdef COPROC_SER_HEX_ASCII_EN
      nib_reg     <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      shreg_reg   <= shreg_next;
      idx_reg     <= idx_next;
      overrun_reg <= overrun_next;
`ifdef COPROC_SER_HEX_ASCII_EN
      nib_reg     <= nib_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    shreg_next   = shreg_reg;
    idx_next     = idx_reg;
    overrun_next = overrun_reg;
`ifdef COPROC_SER_HEX_ASCII_EN
    nib_next     = nib_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (rise) begin
          shreg_next = dout;
          idx_next   = '0;
          state_next = ST_SEND;
`ifdef COPROC_SER_HEX_ASCII_EN
          nib_next   = 1'b0;
`endif
        end
      end
      ST_SEND: begin
`ifdef COPROC_SER_HEX_ASCII_EN
        if (xfer) begin
          nib_next = ~nib_reg;
        end
`endif
        if (byte_done) begin
          shreg_next = shreg_reg << 8;
          idx_next   = idx_reg + 1'b1;
          if (idx_reg == LAST_IDX) begin
            state_next = (APPEND_TERM != 0) ? ST_TERM : ST_IDLE;
          end
        end
      end
      ST_TERM: begin
        if (xfer) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // A new word while a frame is in flight is dropped, only flagged.
    if (rise && (state_reg != ST_IDLE)) begin
      overrun_next = 1'b1;
    end
  end

  always_comb begin
    tx_data = 8'h00;
    case (state_reg)
`ifdef COPROC_SER_HEX_ASCII_EN
      ST_SEND: tx_data = nibble_to_ascii(nib_reg ? shreg_reg[WIDTH_DOUT-5 -: 4]
                                                 : shreg_reg[WIDTH_DOUT-1 -: 4]);
`else
      ST_SEND: tx_data = shreg_reg[WIDTH_DOUT-1 -: 8];
`endif
      ST_TERM: tx_data = TERM_BYTE;
      default: tx_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_coproc_result_serializer.sv
// ---------------------------------------------------------------------------
// tb_coproc_result_serializer
// Lane 0: 128-bit word with terminator. Lane 1: 16-bit word, no terminator.
// Expected byte streams are built from the word with plain indexing and a
// hex character table; a negedge monitor checks every cycle.
// ---------------------------------------------------------------------------
module tb_coproc_result_serializer;

`ifdef COPROC_SER_HEX_ASCII_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [127:0] dout0;
  logic         dv0, tv0, tr0, busy0, ovr0;
  logic [7:0]   td0;
  logic [15:0]  dout1;
  logic         dv1, tv1, tr1, busy1, ovr1;
  logic [7:0]   td1;

  int compared = 0;
  int failed   = 0;

  logic [7:0] exp0[$], exp1[$], got0[$], got1[$];
  int         xfer_cnt[2];
  bit         hold[2];
  logic [7:0] hold_data[2];

  coproc_result_serializer #(.WIDTH_DOUT(128), .APPEND_TERM(1), .TERM_BYTE(8'h0A)) dut_main (
    .clk(clk), .rst(rst), .dout(dout0), .dout_valid(dv0), .tx_data(td0),
    .tx_valid(tv0), .tx_ready(tr0), .busy(busy0), .overrun(ovr0));

  coproc_result_serializer #(.WIDTH_DOUT(16), .APPEND_TERM(0), .TERM_BYTE(8'h0A)) dut_small (
    .clk(clk), .rst(rst), .dout(dout1), .dout_valid(dv1), .tx_data(td1),
    .tx_valid(tv1), .tx_ready(tr1), .busy(busy1), .overrun(ovr1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    string tbl;
    tbl = "0123456789ABCDEF";
    return tbl[n];
  endfunction

  function automatic void push_exp(input int j, input logic [7:0] b);
    if (j == 0) exp0.push_back(b);
    else        exp1.push_back(b);
  endfunction

  function automatic void push_frame(input int j, input logic [127:0] w);
    int         nb;
    logic [7:0] b;
    nb = (j == 0) ? 16 : 2;
    for (int i = nb - 1; i >= 0; i--) begin
      b = w[i*8 +: 8];
      if (HEX) begin
        push_exp(j, hex_char(b[7:4]));
        push_exp(j, hex_char(b[3:0]));
      end else begin
        push_exp(j, b);
      end
    end
    if (j == 0) push_exp(j, 8'h0A);
  endfunction

  function automatic int frame_len(input int j);
    return (j == 0) ? (HEX ? 33 : 17) : (HEX ? 4 : 2);
  endfunction

  // ---------------- monitor ----------------
  task automatic check_lane(input int j, input logic v, input logic [7:0] d,
                            input logic r, input logic b);
    int         depth;
    logic [7:0] e;
    depth = (j == 0) ? exp0.size() : exp1.size();
    compared++;
    if (b !== v) begin
      failed++;
      $display("FAIL busy_vs_valid lane%0d: busy=%b required=%b", j, b, v);
    end
    if (hold[j]) begin
      compared++;
      if (v !== 1'b1 || d !== hold_data[j]) begin
        failed++;
        $display("FAIL hold lane%0d: valid=%b data=%02h required valid=1 data=%02h",
                 j, v, d, hold_data[j]);
      end
    end
    if (v === 1'b1 && depth == 0) begin
      compared++;
      failed++;
      $display("FAIL extra_byte lane%0d: data=%02h required no valid", j, d);
    end else if (v === 1'b1 && r === 1'b1) begin
      e = (j == 0) ? exp0.pop_front() : exp1.pop_front();
      compared++;
      if (d !== e) begin
        failed++;
        $display("FAIL byte lane%0d #%0d: got=%02h required=%02h", j, xfer_cnt[j], d, e);
      end else begin
        $display("lane%0d byte #%0d = %02h", j, xfer_cnt[j], d);
      end
      if (j == 0) got0.push_back(d);
      else        got1.push_back(d);
      xfer_cnt[j]++;
    end
    hold[j]      = (v === 1'b1) && (r !== 1'b1) && (rst === 1'b1);
    hold_data[j] = d;
  endtask

  always @(negedge clk) begin
    check_lane(0, tv0, td0, tr0, busy0);
    check_lane(1, tv1, td1, tr1, busy1);
  end

  // ---------------- driver helpers ----------------
  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic run_until_idle(input int j, input int mode, input int budget);
    int n;
    bit done;
    logic rdy;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      @(posedge clk);
      #1;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (n % 3 == 0);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      if (j == 0) tr0 = rdy;
      else        tr1 = rdy;
      n++;
      if (j == 0) done = (exp0.size() == 0) && (tv0 == 1'b0);
      else        done = (exp1.size() == 0) && (tv1 == 1'b0);
    end
    compared++;
    if (!done) begin
      failed++;
      $display("FAIL timeout_idle lane%0d: cycles=%0d required completion", j, n);
    end
  endtask

  task automatic wait_xfer(input int j, input int target, input int budget);
    int n;
    n = 0;
    while (xfer_cnt[j] < target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    compared++;
    if (xfer_cnt[j] < target) begin
      failed++;
      $display("FAIL timeout_xfer lane%0d: count=%0d required=%0d", j, xfer_cnt[j], target);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] w;
    int           base;
    int           start;
    logic [7:0]   lit[4];

    rst = 1'b0; dv0 = 1'b0; tr0 = 1'b0; dout0 = '0;
    dv1 = 1'b0; tr1 = 1'b0; dout1 = '0;
    xfer_cnt[0] = 0; xfer_cnt[1] = 0;
    hold[0] = 1'b0; hold[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_tx_valid", tv0, 0);
    check_val("reset_busy", busy0, 0);
    check_val("reset_overrun", ovr0, 0);
    check_val("reset_tx_data", td0, 0);
    check_val("reset_small_valid", tv1, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: counting word, ready always high, level held 200 clk
    w = 128'h000102030405060708090A0B0C0D0E0F;
    dout0 = w; tr0 = 1'b1; base = got0.size();
    push_frame(0, w);
    dv0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("latency_not_yet", tv0, 0);
    @(posedge clk);
    #1;
    check_val("latency_valid", tv0, 1);
    repeat (196) @(posedge clk);
    #1;
    check_val("t1_drained", exp0.size(), 0);
    check_val("t1_len", got0.size() - base, frame_len(0));
    check_val("t1_first", got0[base], HEX ? 8'h30 : 8'h00);
    check_val("t1_second", got0[base + 1], HEX ? 8'h30 : 8'h01);
    check_val("t1_last", got0[got0.size() - 1], 8'h0A);
    check_val("t1_busy_low", busy0, 0);
    dv0 = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // 2: same word, ready high one clk in three
    base = got0.size();
    push_frame(0, w);
    dv0 = 1'b1;
    run_until_idle(0, 1, 600);
    check_val("t2_len", got0.size() - base, frame_len(0));
    dv0 = 1'b0; tr0 = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // 3: re-raise during byte 4 -> overrun, frame unaffected
    w = 128'd5;
    dout0 = w; base = got0.size(); start = xfer_cnt[0];
    push_frame(0, w);
    dv0 = 1'b1;
    wait_xfer(0, start + 4, 100);
    dv0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    dv0 = 1'b1;
    run_until_idle(0, 0, 200);
    repeat (20) @(posedge clk);
    #1;
    check_val("t3_overrun", ovr0, 1);
    check_val("t3_len", got0.size() - base, frame_len(0));
    check_val("t3_last_data", got0[got0.size() - 2], HEX ? 8'h35 : 8'h05);
    dv0 = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // 4: reset right after the eighth transfer
    w = 128'h000102030405060708090A0B0C0D0E0F;
    dout0 = w; base = got0.size(); start = xfer_cnt[0];
    push_frame(0, w);
    dv0 = 1'b1; tr0 = 1'b1;
    wait_xfer(0, start + 8, 100);
    rst = 1'b0; tr0 = 1'b0; dv0 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp0.delete();
    check_val("t4_valid_after_rst", tv0, 0);
    check_val("t4_busy_after_rst", busy0, 0);
    check_val("t4_overrun_cleared", ovr0, 0);
    check_val("t4_partial_len", got0.size() - base, 8);
    repeat (5) @(posedge clk);
    #1;
    check_val("t4_quiet", tv0, 0);
    w = {$urandom, $urandom, $urandom, $urandom};
    dout0 = w; base = got0.size();
    push_frame(0, w);
    dv0 = 1'b1;
    run_until_idle(0, 0, 200);
    check_val("t4_fresh_len", got0.size() - base, frame_len(0));
    dv0 = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // 5: 16-bit lane, no terminator, 16'hBEEF
    dout1 = 16'hBEEF; base = got1.size();
    push_frame(1, {112'd0, 16'hBEEF});
    dv1 = 1'b1;
    run_until_idle(1, 0, 100);
    if (HEX) begin
      lit[0] = 8'h42; lit[1] = 8'h45; lit[2] = 8'h45; lit[3] = 8'h46;
    end else begin
      lit[0] = 8'hBE; lit[1] = 8'hEF; lit[2] = 8'h00; lit[3] = 8'h00;
    end
    check_val("t5_len", got1.size() - base, frame_len(1));
    for (int i = 0; i < frame_len(1); i++) check_val("t5_byte", got1[base + i], lit[i]);
    dv1 = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // 6: 16'h1A2F on the small lane (hex build gives 31 41 32 46)
    dout1 = 16'h1A2F; base = got1.size();
    push_frame(1, {112'd0, 16'h1A2F});
    dv1 = 1'b1;
    run_until_idle(1, 2, 100);
    if (HEX) begin
      lit[0] = 8'h31; lit[1] = 8'h41; lit[2] = 8'h32; lit[3] = 8'h46;
    end else begin
      lit[0] = 8'h1A; lit[1] = 8'h2F; lit[2] = 8'h00; lit[3] = 8'h00;
    end
    for (int i = 0; i < frame_len(1); i++) check_val("t6_byte", got1[base + i], lit[i]);
    dv1 = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // random words with random back-pressure on both lanes
    for (int k = 0; k < 6; k++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      dout0 = w; base = got0.size();
      push_frame(0, w);
      dv0 = 1'b1;
      run_until_idle(0, 2, 400);
      check_val("rand_len", got0.size() - base, frame_len(0));
      dv0 = 1'b0;
      dout1 = 16'($urandom);
      push_frame(1, {112'd0, dout1});
      dv1 = 1'b1;
      run_until_idle(1, 2, 100);
      dv1 = 1'b0;
      repeat (5) @(posedge clk);
      #1;
    end

    check_val("final_overrun_main", ovr0, 0);
    check_val("final_overrun_small", ovr1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
